// File: rtl/pwm_capture_pkg.sv
// Shared constants for the PWM capture block: FSM state encoding and counter limit helper.
// No timing of its own.
// No flow control.
package pwm_capture_pkg;

    // Measurement FSM states, kept as plain 2-bit constants for legacy tools.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    // Saturation value of a w-bit cycle counter (2^w - 1).
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Synchronizes an asynchronous level into clk and derives single-cycle rise/fall strobes.
// Latency: SYNC_STAGES cycles to s, strobes valid in the cycle s first shows the new level.
// No backpressure; runs every cycle regardless of enable.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   s_d;

    // Shift the raw input through the synchronizer, then keep one delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
            s_d   <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            s_d   <= chain[SYNC_STAGES-1];
        end
    end

    assign s    = chain[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of an incoming PWM signal; flags a static input.
// Latency: publish one cycle after the synchronized closing rise (SYNC_STAGES+1 after pwm_in).
// No backpressure; valid is a single-cycle pulse, results hold until the next publish.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             stuck_low,
    output logic             stuck_high
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic             s;
    logic             rise;
    logic             fall;
    logic [1:0]       state;
    logic [CNT_W-1:0] p_cnt;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] h_lat;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (pwm_in),
        .s      (s),
        .rise   (rise),
        .fall   (fall)
    );

    // Measurement FSM: count period and high time, latch high time on fall, publish on the closing rise.
    // An edge in the saturation cycle takes priority over the timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            p_cnt      <= '0;
            h_cnt      <= '0;
            h_lat      <= '0;
            high_time  <= '0;
            period     <= '0;
            valid      <= 1'b0;
            stuck_low  <= 1'b0;
            stuck_high <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!enable) begin
                // Discard any partial period; results stay on the outputs.
                state      <= ST_IDLE;
                p_cnt      <= '0;
                h_cnt      <= '0;
                stuck_low  <= 1'b0;
                stuck_high <= 1'b0;
            end else if ((p_cnt == CNT_MAX) && !rise && !fall) begin
                // No edge for a full counter span: report the level we are stuck at.
                stuck_high <= s;
                stuck_low  <= ~s;
                p_cnt      <= '0;
                h_cnt      <= '0;
                state      <= ST_IDLE;
            end else begin
                case (state)
                    ST_HIGH: begin
                        if (fall) begin
                            h_lat <= h_cnt;
                            p_cnt <= p_cnt + ONE;
                            state <= ST_LOW;
                        end else begin
                            p_cnt <= p_cnt + ONE;
                            h_cnt <= h_cnt + ONE;
                        end
                    end
                    ST_LOW: begin
                        if (rise) begin
                            high_time  <= h_lat;
                            period     <= p_cnt;
                            valid      <= 1'b1;
                            stuck_low  <= 1'b0;
                            stuck_high <= 1'b0;
                            p_cnt      <= ONE;
                            h_cnt      <= ONE;
                            state      <= ST_HIGH;
                        end else begin
                            p_cnt <= p_cnt + ONE;
                        end
                    end
                    default: begin
                        // Waiting for the first rise; a fall here carries no information.
                        if (rise) begin
                            p_cnt <= ONE;
                            h_cnt <= ONE;
                            state <= ST_HIGH;
                        end else begin
                            p_cnt <= p_cnt + ONE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: waveform segments drive pwm_in, an edge-timestamp model predicts publishes.
// Latency of the DUT is not modelled; only the order and content of publishes and flag levels are checked.
// No backpressure involved.
module tb_pwm_capture;

    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int GEN_PER     = 16;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b1;
    logic             enable  = 1'b1;
    logic             pwm_in  = 1'b0;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             stuck_low;
    logic             stuck_high;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model: timestamps of input edges since the last restart.
    int q_h[$];
    int q_p[$];
    int rise_t = -1;
    int fall_t = -1;
    int last_h = 0;
    int last_p = 0;
    int eh, ep;

    pwm_capture #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .pwm_in    (pwm_in),
        .high_time (high_time),
        .period    (period),
        .valid     (valid),
        .stuck_low (stuck_low),
        .stuck_high(stuck_high)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used to timestamp input edges.
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every valid pulse must match the oldest predicted measurement.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vectors++;
            if (q_h.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_valid: got high_time=%0d period=%0d, required no publish",
                         high_time, period);
            end else begin
                eh = q_h.pop_front();
                ep = q_p.pop_front();
                if (int'(high_time) !== eh || int'(period) !== ep) begin
                    miscompares++;
                    $display("FAIL publish: got high_time=%0d period=%0d, required %0d/%0d",
                             high_time, period, eh, ep);
                end
                last_h = eh;
                last_p = ep;
            end
            vectors++;
            if ({stuck_low, stuck_high} !== 2'b00) begin
                miscompares++;
                $display("FAIL flags_at_publish: got low=%b high=%b, required 0/0", stuck_low, stuck_high);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic model_edge(input logic lvl);
        if (lvl) begin
            if (rise_t >= 0 && fall_t >= 0) begin
                q_h.push_back(fall_t - rise_t);
                q_p.push_back(cyc - rise_t);
            end
            rise_t = cyc;
            fall_t = -1;
        end else if (rise_t >= 0) begin
            fall_t = cyc;
        end
    endtask

    task automatic model_restart();
        rise_t = -1;
        fall_t = -1;
    endtask

    task automatic drive_seg(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0 && lvl !== pwm_in) model_edge(lvl);
            pwm_in = lvl;
        end
    endtask

    task automatic gen(input int duty, input int n);
        for (int k = 0; k < n; k++) begin
            if (duty > 0) drive_seg(1'b1, duty);
            if (duty < GEN_PER) drive_seg(1'b0, GEN_PER - duty);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && q_h.size() != 0; i++) @(negedge clk);
        vectors++;
        if (q_h.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d publishes outstanding, required 0", name, q_h.size());
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        pwm_in = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (high_time !== '0 || period !== '0) begin
            miscompares++;
            $display("FAIL reset_results: got %0d/%0d, required 0/0", high_time, period);
        end
        vectors++;
        if ({valid, stuck_low, stuck_high} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got valid=%b low=%b high=%b, required 0", valid, stuck_low, stuck_high);
        end
    endtask

    task automatic test_stuck_low();
        @(negedge clk);
        reset_n = 1'b1;
        repeat ((1 << CNT_W) - 1) @(negedge clk);
        vectors++;
        if (stuck_low !== 1'b0) begin
            miscompares++;
            $display("FAIL stuck_low_early: got %b, required 0", stuck_low);
        end
        @(negedge clk);
        vectors++;
        if (stuck_low !== 1'b1 || stuck_high !== 1'b0) begin
            miscompares++;
            $display("FAIL stuck_low_set: got low=%b high=%b, required 1/0", stuck_low, stuck_high);
        end
        repeat (300) @(negedge clk);
        vectors++;
        if (stuck_low !== 1'b1) begin
            miscompares++;
            $display("FAIL stuck_low_repeat: got %b, required 1", stuck_low);
        end
        drive_seg(1'b1, 3);
        vectors++;
        if (stuck_low !== 1'b1) begin
            miscompares++;
            $display("FAIL stuck_low_hold: got %b, required 1 before first publish", stuck_low);
        end
        drive_seg(1'b0, GEN_PER - 3);
        gen(3, 3);
        wait_drain("stuck_low");
        vectors++;
        if (stuck_low !== 1'b0 || int'(high_time) !== 3 || int'(period) !== GEN_PER) begin
            miscompares++;
            $display("FAIL stuck_low_recover: got low=%b %0d/%0d, required 0 3/16", stuck_low, high_time, period);
        end
    endtask

    task automatic test_loopback();
        int d;
        gen(5, 4);
        wait_drain("loopback5");
        vectors++;
        if (int'(high_time) !== 5 || int'(period) !== GEN_PER) begin
            miscompares++;
            $display("FAIL loopback5: got %0d/%0d, required 5/16", high_time, period);
        end
        for (int k = 0; k < 4; k++) begin
            d = $urandom_range(1, GEN_PER - 1);
            gen(d, 3);
        end
        wait_drain("loopback_rand");
    endtask

    task automatic test_duty_switch();
        gen(5, 3);
        gen(12, 4);
        wait_drain("duty_switch");
        vectors++;
        if (int'(high_time) !== 12 || int'(period) !== GEN_PER) begin
            miscompares++;
            $display("FAIL duty_switch: got %0d/%0d, required 12/16", high_time, period);
        end
    endtask

    task automatic test_random_widths();
        for (int k = 0; k < 40; k++) begin
            drive_seg(1'b1, $urandom_range(1, 30));
            drive_seg(1'b0, $urandom_range(1, 30));
        end
        wait_drain("random_widths");
    endtask

    task automatic test_saturate();
        drive_seg(1'b1, 10);
        drive_seg(1'b0, (1 << CNT_W) - 1 - 10);
        drive_seg(1'b1, 10);
        drive_seg(1'b0, 10);
        wait_drain("saturate");
        vectors++;
        if (int'(high_time) !== 10 || int'(period) !== (1 << CNT_W) - 1 || stuck_low !== 1'b0) begin
            miscompares++;
            $display("FAIL saturate: got %0d/%0d low=%b, required 10/%0d 0",
                     high_time, period, stuck_low, (1 << CNT_W) - 1);
        end
    endtask

    task automatic test_stuck_high();
        drive_seg(1'b1, 300);
        model_restart();
        vectors++;
        if (stuck_high !== 1'b1 || stuck_low !== 1'b0) begin
            miscompares++;
            $display("FAIL stuck_high_set: got high=%b low=%b, required 1/0", stuck_high, stuck_low);
        end
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        vectors++;
        if (stuck_high !== 1'b0 || stuck_low !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_clears_flags: got high=%b low=%b, required 0/0", stuck_high, stuck_low);
        end
        enable = 1'b1;
        drive_seg(1'b1, 300);
        vectors++;
        if (stuck_high !== 1'b1) begin
            miscompares++;
            $display("FAIL stuck_high_reassert: got %b, required 1", stuck_high);
        end
        gen(7, 4);
        wait_drain("stuck_high");
        vectors++;
        if (stuck_high !== 1'b0 || int'(high_time) !== 7 || int'(period) !== GEN_PER) begin
            miscompares++;
            $display("FAIL stuck_high_recover: got high=%b %0d/%0d, required 0 7/16", stuck_high, high_time, period);
        end
    endtask

    task automatic test_reset_mid_high();
        gen(5, 2);
        drive_seg(1'b1, 5);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (high_time !== '0 || period !== '0 || {valid, stuck_low, stuck_high} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_immediate: got %0d/%0d v=%b l=%b h=%b, required all 0",
                     high_time, period, valid, stuck_low, stuck_high);
        end
        model_restart();
        last_h = 0;
        last_p = 0;
        drive_seg(1'b0, 6);
        reset_n = 1'b1;
        drive_seg(1'b0, 5);
        gen(5, 3);
        wait_drain("reset_mid_high");
        vectors++;
        if (int'(high_time) !== 5 || int'(period) !== GEN_PER) begin
            miscompares++;
            $display("FAIL reset_recover: got %0d/%0d, required 5/16", high_time, period);
        end
    endtask

    task automatic test_enable_gap();
        gen(5, 2);
        drive_seg(1'b1, 5);
        drive_seg(1'b0, 4);
        enable = 1'b0;
        model_restart();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if ({valid, stuck_low, stuck_high} !== 3'b000) begin
                miscompares++;
                $display("FAIL enable_low_flags: got v=%b l=%b h=%b, required 0", valid, stuck_low, stuck_high);
            end
            vectors++;
            if (int'(high_time) !== last_h || int'(period) !== last_p) begin
                miscompares++;
                $display("FAIL enable_low_hold: got %0d/%0d, required %0d/%0d", high_time, period, last_h, last_p);
            end
        end
        enable = 1'b1;
        drive_seg(1'b0, 7);
        gen(5, 3);
        wait_drain("enable_gap");
        vectors++;
        if (int'(high_time) !== 5 || int'(period) !== GEN_PER) begin
            miscompares++;
            $display("FAIL enable_recover: got %0d/%0d, required 5/16", high_time, period);
        end
    endtask

    initial begin
        test_reset();
        test_stuck_low();
        test_loopback();
        test_duty_switch();
        test_random_widths();
        test_saturate();
        test_stuck_high();
        test_reset_mid_high();
        test_enable_gap();
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
